// File: rtl/legv8_control_unit.sv
// LEGv8 multi-cycle control unit: FETCH0/FETCH1/EXEC(/MEM) sequencing and control-word decode.
// Define LEGV8_BCOND_EN to add the captured {V,C,N,Z} flag register and B.cond support.
module legv8_control_unit #(
    parameter logic HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] CONSIG,
    input  logic [3:0]  STAT,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic        WR,
    output logic        IR,
    output logic [4:0]  FS,
    output logic        C0,
    output logic [63:0] K,
    output logic        M,
    output logic        EN_ALU,
    output logic        EN_ADDR_ALU,
    output logic        EN_B,
    output logic        EN_PC,
    output logic        EN_ADDR_PC,
    output logic        PC_SEL,
    output logic [1:0]  PS,
    output logic        RCS,
    output logic        RWE,
    output logic        ROE,
    output logic        ILLEGAL,
    output logic [2:0]  STATE
);

    typedef enum logic [2:0] {
        FETCH0 = 3'b000,
        FETCH1 = 3'b001,
        EXEC   = 3'b010,
        MEM    = 3'b011,
        HALT   = 3'b100
    } state_t;

    typedef enum logic [4:0] {
        I_ILL, I_ADD, I_SUB, I_AND, I_ORR, I_EOR, I_ADDS, I_SUBS, I_LSL, I_LSR,
        I_ADDI, I_SUBI, I_ADDIS, I_SUBIS, I_ANDI, I_ORRI, I_EORI,
        I_STUR, I_LDUR, I_B, I_BR, I_CBZ, I_CBNZ, I_BCOND
    } insn_t;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_EOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    state_t      state_q, state_d;
    insn_t       insn;
    logic [4:0]  rd, rn, rm;
    logic [63:0] k_shamt, k_imm12, k_dt, k_br26, k_br19;
    logic        cb_taken, bcond_taken;

    assign rd      = CONSIG[4:0];
    assign rn      = CONSIG[9:5];
    assign rm      = CONSIG[20:16];
    assign k_shamt = {58'b0, CONSIG[15:10]};
    assign k_imm12 = {52'b0, CONSIG[21:10]};
    assign k_dt    = {{55{CONSIG[20]}}, CONSIG[20:12]};
    // Branch offsets are pre-decremented because the PC already advanced by 4 during FETCH1.
    assign k_br26  = {{38{CONSIG[25]}}, CONSIG[25:0]} - 64'd1;
    assign k_br19  = {{45{CONSIG[23]}}, CONSIG[23:5]} - 64'd1;
    assign cb_taken = STAT[0] ^ (insn == I_CBNZ);
    assign STATE   = state_q;

    always_comb begin
        insn = I_ILL;
        casez (CONSIG[31:21])
            11'b10001011000: insn = I_ADD;
            11'b11001011000: insn = I_SUB;
            11'b10001010000: insn = I_AND;
            11'b10101010000: insn = I_ORR;
            11'b11001010000: insn = I_EOR;
            11'b10101011000: insn = I_ADDS;
            11'b11101011000: insn = I_SUBS;
            11'b11010011011: insn = I_LSL;
            11'b11010011010: insn = I_LSR;
            11'b1001000100?: insn = I_ADDI;
            11'b1101000100?: insn = I_SUBI;
            11'b1011000100?: insn = I_ADDIS;
            11'b1111000100?: insn = I_SUBIS;
            11'b1001001000?: insn = I_ANDI;
            11'b1011001000?: insn = I_ORRI;
            11'b1101001000?: insn = I_EORI;
            11'b11111000000: insn = I_STUR;
            11'b11111000010: insn = I_LDUR;
            11'b000101?????: insn = I_B;
            11'b11010110000: insn = I_BR;
            11'b10110100???: insn = I_CBZ;
            11'b10110101???: insn = I_CBNZ;
`ifdef LEGV8_BCOND_EN
            11'b01010100???: insn = I_BCOND;
`endif
            default:         insn = I_ILL;
        endcase
    end

`ifdef LEGV8_BCOND_EN
    logic [3:0] flags_q, flags_d;
    logic       fv, fc, fn, fz;

    always_comb begin
        {fv, fc, fn, fz} = flags_q;
        case (CONSIG[3:0])
            4'h0:    bcond_taken = fz;
            4'h1:    bcond_taken = !fz;
            4'h2:    bcond_taken = fc;
            4'h3:    bcond_taken = !fc;
            4'h4:    bcond_taken = fn;
            4'h5:    bcond_taken = !fn;
            4'h6:    bcond_taken = fv;
            4'h7:    bcond_taken = !fv;
            4'h8:    bcond_taken = fc && !fz;
            4'h9:    bcond_taken = !fc || fz;
            4'hA:    bcond_taken = (fn == fv);
            4'hB:    bcond_taken = (fn != fv);
            4'hC:    bcond_taken = !fz && (fn == fv);
            4'hD:    bcond_taken = fz || (fn != fv);
            default: bcond_taken = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (state_q == EXEC &&
            (insn == I_ADDS || insn == I_SUBS || insn == I_ADDIS || insn == I_SUBIS))
            flags_d = STAT;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) flags_q <= '0;
        else     flags_q <= flags_d;
    end
`else
    logic stat_unused;
    assign stat_unused = ^STAT[3:1];
    assign bcond_taken = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH0: state_d = FETCH1;
            FETCH1: state_d = EXEC;
            EXEC: begin
                if (insn == I_LDUR)                         state_d = MEM;
                else if (insn == I_ILL && HALT_ON_ILLEGAL) state_d = HALT;
                else                                        state_d = FETCH0;
            end
            MEM:     state_d = FETCH0;
            HALT:    state_d = HALT;
            default: state_d = FETCH0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= FETCH0;
        else     state_q <= state_d;
    end

    always_comb begin
        SA = '0; SB = '0; DA = '0; WR = 1'b0; IR = 1'b0; FS = '0; C0 = 1'b0;
        K = '0; M = 1'b0; EN_ALU = 1'b0; EN_ADDR_ALU = 1'b0; EN_B = 1'b0;
        EN_PC = 1'b0; EN_ADDR_PC = 1'b0; PC_SEL = 1'b0; PS = 2'b00;
        RCS = 1'b0; RWE = 1'b0; ROE = 1'b0; ILLEGAL = 1'b0;
        case (state_q)
            FETCH0: begin
                EN_ADDR_PC = 1'b1; RCS = 1'b1;
            end
            FETCH1: begin
                EN_ADDR_PC = 1'b1; RCS = 1'b1; ROE = 1'b1; IR = 1'b1; PS = 2'b01;
            end
            EXEC: begin
                case (insn)
                    I_ADD, I_SUB, I_AND, I_ORR, I_EOR, I_ADDS, I_SUBS: begin
                        SA = rn; SB = rm; M = 1'b1; DA = rd; WR = 1'b1; EN_ALU = 1'b1;
                    end
                    I_LSL, I_LSR: begin
                        SA = rn; SB = rm; K = k_shamt; DA = rd; WR = 1'b1; EN_ALU = 1'b1;
                    end
                    I_ADDI, I_SUBI, I_ADDIS, I_SUBIS, I_ANDI, I_ORRI, I_EORI: begin
                        SA = rn; K = k_imm12; DA = rd; WR = 1'b1; EN_ALU = 1'b1;
                    end
                    I_STUR: begin
                        SA = rn; K = k_dt; FS = FS_ADD; EN_ADDR_ALU = 1'b1;
                        SB = rd; EN_B = 1'b1; RCS = 1'b1; RWE = 1'b1;
                    end
                    I_LDUR: begin
                        SA = rn; K = k_dt; FS = FS_ADD; EN_ADDR_ALU = 1'b1; RCS = 1'b1;
                    end
                    I_B: begin
                        PS = 2'b11; PC_SEL = 1'b1; K = k_br26;
                    end
                    I_BR: begin
                        SA = rn; PS = 2'b10;
                    end
                    // ALU sees A+K for the zero test; K only carries the offset when the PC takes it.
                    I_CBZ, I_CBNZ: begin
                        SA = rd; FS = FS_ADD;
                        if (cb_taken) begin
                            PS = 2'b11; PC_SEL = 1'b1; K = k_br19;
                        end
                    end
                    I_BCOND: begin
                        if (bcond_taken) begin
                            PS = 2'b11; PC_SEL = 1'b1; K = k_br19;
                        end
                    end
                    default: ILLEGAL = 1'b1;
                endcase
                case (insn)
                    I_AND, I_ANDI:                   FS = FS_AND;
                    I_ORR, I_ORRI:                   FS = FS_ORR;
                    I_EOR, I_EORI:                   FS = FS_EOR;
                    I_ADD, I_ADDS, I_ADDI, I_ADDIS:  FS = FS_ADD;
                    I_SUB, I_SUBS, I_SUBI, I_SUBIS: begin
                        FS = FS_SUB; C0 = 1'b1;
                    end
                    I_LSL:                           FS = FS_LSL;
                    I_LSR:                           FS = FS_LSR;
                    default: ;
                endcase
            end
            MEM: begin
                SA = rn; K = k_dt; FS = FS_ADD; EN_ADDR_ALU = 1'b1; RCS = 1'b1;
                ROE = 1'b1; DA = rd; WR = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_legv8_control_unit.sv
// Scoreboard bench for legv8_control_unit: an instruction-level model predicts each cycle's control word.
// Honors LEGV8_BCOND_EN the same way as the design.
module tb_legv8_control_unit;

    localparam logic HALT_P = 1'b1;
`ifdef LEGV8_BCOND_EN
    localparam bit BCOND_EN = 1'b1;
`else
    localparam bit BCOND_EN = 1'b0;
`endif

    localparam int O_ADD = 0, O_SUB = 1, O_AND = 2, O_ORR = 3, O_EOR = 4, O_ADDS = 5,
                   O_SUBS = 6, O_LSL = 7, O_LSR = 8, O_ADDI = 9, O_SUBI = 10, O_ADDIS = 11,
                   O_SUBIS = 12, O_ANDI = 13, O_ORRI = 14, O_EORI = 15, O_STUR = 16,
                   O_LDUR = 17, O_B = 18, O_BR = 19, O_CBZ = 20, O_CBNZ = 21, O_BCOND = 22,
                   O_ILL = 23;
    localparam int N_OPS = 23;

    typedef struct packed {
        logic [4:0]  sa, sb, da;
        logic        wr, ir;
        logic [4:0]  fs;
        logic        c0;
        logic [63:0] k;
        logic        m, en_alu, en_addr_alu, en_b, en_pc, en_addr_pc, pc_sel;
        logic [1:0]  ps;
        logic        rcs, rwe, roe, ill;
        logic [2:0]  st;
    } ctrl_t;

    logic        clk;
    logic        RST;
    logic [31:0] CONSIG;
    logic [3:0]  STAT;
    logic [4:0]  SA, SB, DA, FS;
    logic        WR, IR, C0, M, EN_ALU, EN_ADDR_ALU, EN_B, EN_PC, EN_ADDR_PC, PC_SEL;
    logic [63:0] K;
    logic [1:0]  PS;
    logic        RCS, RWE, ROE, ILLEGAL;
    logic [2:0]  STATE;

    legv8_control_unit #(.HALT_ON_ILLEGAL(HALT_P)) dut (
        .CLK(clk), .RST(RST), .CONSIG(CONSIG), .STAT(STAT),
        .SA(SA), .SB(SB), .DA(DA), .WR(WR), .IR(IR), .FS(FS), .C0(C0), .K(K), .M(M),
        .EN_ALU(EN_ALU), .EN_ADDR_ALU(EN_ADDR_ALU), .EN_B(EN_B), .EN_PC(EN_PC),
        .EN_ADDR_PC(EN_ADDR_PC), .PC_SEL(PC_SEL), .PS(PS), .RCS(RCS), .RWE(RWE),
        .ROE(ROE), .ILLEGAL(ILLEGAL), .STATE(STATE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ctrl_t      sb[$];
    int         checks = 0;
    int         passed = 0;
    int         phase;
    logic [3:0] flags;

    // Opcode table: width of the opcode field (from bit 31 down) and its value.
    function automatic void op_entry(input int idx, output int w, output int unsigned v);
        case (idx)
            O_ADD:   begin w = 11; v = 'h458; end
            O_SUB:   begin w = 11; v = 'h658; end
            O_AND:   begin w = 11; v = 'h450; end
            O_ORR:   begin w = 11; v = 'h550; end
            O_EOR:   begin w = 11; v = 'h650; end
            O_ADDS:  begin w = 11; v = 'h558; end
            O_SUBS:  begin w = 11; v = 'h758; end
            O_LSL:   begin w = 11; v = 'h69B; end
            O_LSR:   begin w = 11; v = 'h69A; end
            O_ADDI:  begin w = 10; v = 'h244; end
            O_SUBI:  begin w = 10; v = 'h344; end
            O_ADDIS: begin w = 10; v = 'h2C4; end
            O_SUBIS: begin w = 10; v = 'h3C4; end
            O_ANDI:  begin w = 10; v = 'h248; end
            O_ORRI:  begin w = 10; v = 'h2C8; end
            O_EORI:  begin w = 10; v = 'h348; end
            O_STUR:  begin w = 11; v = 'h7C0; end
            O_LDUR:  begin w = 11; v = 'h7C2; end
            O_B:     begin w = 6;  v = 'h05;  end
            O_BR:    begin w = 11; v = 'h6B0; end
            O_CBZ:   begin w = 8;  v = 'hB4;  end
            O_CBNZ:  begin w = 8;  v = 'hB5;  end
            default: begin w = 8;  v = 'h54;  end
        endcase
    endfunction

    function automatic int kind(input logic [31:0] in);
        int w;
        int unsigned v;
        for (int i = 0; i < N_OPS; i++) begin
            op_entry(i, w, v);
            if (i == O_BCOND && !BCOND_EN) continue;
            if ((in >> (32 - w)) == v) return i;
        end
        return O_ILL;
    endfunction

    function automatic logic [31:0] gen(input int idx);
        logic [31:0] r;
        int w;
        int unsigned v;
        r = $urandom;
        if (idx >= O_ILL) begin
            while (kind(r) != O_ILL) r = $urandom;
            return r;
        end
        op_entry(idx, w, v);
        return (32'(v) << (32 - w)) | (r & ((32'd1 << (32 - w)) - 32'd1));
    endfunction

    function automatic int alu_op(input int id);
        case (id)
            O_AND, O_ANDI: return 0;
            O_ORR, O_ORRI: return 1;
            O_ADD, O_ADDS, O_ADDI, O_ADDIS, O_SUB, O_SUBS, O_SUBI, O_SUBIS: return 2;
            O_EOR, O_EORI: return 3;
            O_LSL: return 4;
            O_LSR: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic bit cond_holds(input logic [3:0] fl, input logic [3:0] code);
        bit v, c, n, z, base;
        v = fl[3]; c = fl[2]; n = fl[1]; z = fl[0];
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b0;
        endcase
        return code[0] ? !base : base;
    endfunction

    function automatic ctrl_t model(input int ph, input logic [31:0] in, input logic [3:0] st,
                                    input logic [3:0] fl);
        ctrl_t  e;
        int     id, op;
        bit     sub, taken;
        longint dt, tgt19, tgt26;
        e     = '0;
        id    = kind(in);
        op    = alu_op(id);
        sub   = id inside {O_SUB, O_SUBS, O_SUBI, O_SUBIS};
        dt    = longint'($signed(in[20:12]));
        tgt19 = longint'($signed(in[23:5])) - 1;
        tgt26 = longint'($signed(in[25:0])) - 1;
        e.st  = 3'(ph);
        case (ph)
            0: begin e.en_addr_pc = 1; e.rcs = 1; end
            1: begin e.en_addr_pc = 1; e.rcs = 1; e.roe = 1; e.ir = 1; e.ps = 2'd1; end
            2: begin
                if (op >= 0) begin
                    e.sa = in[9:5]; e.da = in[4:0]; e.wr = 1; e.en_alu = 1;
                    e.fs = 5'(op * 4 + (sub ? 1 : 0)); e.c0 = sub;
                    if (id <= O_SUBS) begin e.sb = in[20:16]; e.m = 1; end
                    else if (id == O_LSL || id == O_LSR) begin
                        e.sb = in[20:16]; e.k = 64'(in[15:10]);
                    end
                    else e.k = 64'(in[21:10]);
                end
                else case (id)
                    O_STUR, O_LDUR: begin
                        e.sa = in[9:5]; e.k = 64'(dt); e.fs = 5'd8; e.en_addr_alu = 1; e.rcs = 1;
                        if (id == O_STUR) begin e.sb = in[4:0]; e.en_b = 1; e.rwe = 1; end
                    end
                    O_B:  begin e.ps = 2'd3; e.pc_sel = 1; e.k = 64'(tgt26); end
                    O_BR: begin e.sa = in[9:5]; e.ps = 2'd2; end
                    O_CBZ, O_CBNZ: begin
                        e.sa = in[4:0]; e.fs = 5'd8;
                        taken = (st[0] == 1'b1) == (id == O_CBZ);
                        if (taken) begin e.ps = 2'd3; e.pc_sel = 1; e.k = 64'(tgt19); end
                    end
                    O_BCOND: begin
                        if (cond_holds(fl, in[3:0])) begin
                            e.ps = 2'd3; e.pc_sel = 1; e.k = 64'(tgt19);
                        end
                    end
                    default: e.ill = 1;
                endcase
            end
            3: begin
                e.sa = in[9:5]; e.k = 64'(dt); e.fs = 5'd8; e.en_addr_alu = 1; e.rcs = 1;
                e.roe = 1; e.da = in[4:0]; e.wr = 1;
            end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        ctrl_t exp_c, act_c;
        if (sb.size() != 0) begin
            exp_c = sb.pop_front();
            act_c = {SA, SB, DA, WR, IR, FS, C0, K, M, EN_ALU, EN_ADDR_ALU, EN_B, EN_PC,
                     EN_ADDR_PC, PC_SEL, PS, RCS, RWE, ROE, ILLEGAL, STATE};
            checks++;
            if (act_c === exp_c) passed++;
            else $display("FAIL ctrl phase=%0d insn=%h stat=%h got=%h want=%h",
                          exp_c.st, CONSIG, STAT, act_c, exp_c);
        end
    end

    task automatic step(input logic [3:0] st);
        int id, nxt;
        logic [3:0] fl_n;
        STAT = st;
        id   = kind(CONSIG);
        sb.push_back(model(phase, CONSIG, STAT, flags));
        fl_n = flags;
        case (phase)
            0: nxt = 1;
            1: nxt = 2;
            2: begin
                nxt = (id == O_LDUR) ? 3 : (id == O_ILL && HALT_P) ? 4 : 0;
                if (BCOND_EN && id inside {O_ADDS, O_SUBS, O_ADDIS, O_SUBIS}) fl_n = st;
            end
            3: nxt = 0;
            default: nxt = 4;
        endcase
        @(posedge clk); #1;
        phase = nxt;
        flags = fl_n;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        sb.push_back(model(0, CONSIG, STAT, 4'h0));
        @(posedge clk); #1;
        RST   = 1'b0;
        phase = 0;
        flags = '0;
    endtask

    task automatic run(input logic [31:0] insn, input logic [3:0] st, input bit rnd,
                       input bit rst_exec);
        CONSIG = insn;
        do begin
            if (rst_exec && phase == 2) begin
                pulse_reset();
                return;
            end
            step(rnd ? 4'($urandom) : st);
        end while (phase != 0 && phase != 4);
        if (phase == 4) begin
            repeat (4) step(4'($urandom));
            pulse_reset();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; CONSIG = '0; STAT = '0; phase = 0; flags = '0;
        @(posedge clk); #1;
        pulse_reset();

        run(32'h8B020020, 4'h0, 1'b1, 1'b0);   // ADD X0,X1,X2
        run(32'hF85F8083, 4'h0, 1'b1, 1'b0);   // LDUR X3,[X4,#-8]
        run(32'hB4000065, 4'h1, 1'b0, 1'b0);   // CBZ X5,+3 taken
        run(32'hB4000065, 4'h0, 1'b0, 1'b0);   // CBZ X5,+3 not taken
        run(32'hB5000065, 4'h0, 1'b0, 1'b0);   // CBNZ X5,+3 taken
        run(32'h8B020020, 4'h0, 1'b1, 1'b1);   // reset during EXEC of ADD
        run(32'hEB030041, 4'h1, 1'b0, 1'b0);   // SUBS X1,X2,X3 with Z=1
        run(32'h54000060, 4'h0, 1'b1, 1'b0);   // B.EQ +3
        run(32'hEB030041, 4'h1, 1'b0, 1'b0);
        run(32'h54000061, 4'h0, 1'b1, 1'b0);   // B.NE +3
        run(32'h17FFFFFF, 4'h0, 1'b1, 1'b0);   // B -1
        run(32'hD61F0140, 4'h0, 1'b1, 1'b0);   // BR X10

        repeat (1500)
            run(gen($urandom_range(O_ILL)), 4'h0, 1'b1, $urandom_range(39) == 0);

        run(32'h00000000, 4'h0, 1'b1, 1'b0);   // illegal: halt, then reset
        run(32'h8B020020, 4'h0, 1'b1, 1'b0);

        @(negedge clk); #1;
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain got=%0d pending want=0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
Multi-cycle control unit for the LEGv8 datapath.
- Consumes the instruction-register word CONSIG and the ALU status STAT.
- Produces the full control word that the datapath consumes: register selects, ALU function, constant K, bus-enables, PC control and RAM strobes.
- Sequences fetch (two cycles, synchronous-read RAM), execute, and an extra memory cycle for loads.

Parameters:
HALT_ON_ILLEGAL, 0, 1: an undecoded opcode enters HALT until reset. 0: it executes as NOP.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
CONSIG  in  32  current instruction word from the instruction register
STAT  in  4  ALU status {V,C,N,Z} = STAT[3:0]
SA, SB, DA  out  5 each  A-bus, B-bus and destination register selects
WR  out  1  register-file write enable
IR  out  1  instruction-register load
FS  out  5  ALU function = {op[2:0], invA, invB}; op: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR
C0  out  1  ALU carry-in
K  out  64  constant
M  out  1  ALU B-input select: 0 = K, 1 = register B
EN_ALU, EN_ADDR_ALU, EN_B, EN_PC, EN_ADDR_PC  out  1 each  tri-state bus enables
PC_SEL  out  1  PC input select: 0 = A bus, 1 = K
PS  out  2  PC op: 00 hold, 01 PC+4, 10 PC←in·4, 11 PC←PC+in·4
RCS, RWE, ROE  out  1 each  RAM chip select, write enable, output enable
ILLEGAL  out  1  high during EXEC of an undecoded opcode
STATE  out  3  FSM state, for debug

Behaviour:
- FSM states: FETCH0=000, FETCH1=001, EXEC=010, MEM=011, HALT=100. All outputs are combinational from state and CONSIG.
- Reset puts the FSM in FETCH0. Outputs then take FETCH0 values: EN_ADDR_PC=1, RCS=1, all other outputs 0. This applies mid-instruction too; nothing is retained across reset.
- FETCH0 → FETCH1: present the PC address (EN_ADDR_PC=1, RCS=1).
- FETCH1 → EXEC: same outputs plus ROE=1, IR=1, PS=01. IR and PC update on the same edge.
- EXEC: default outputs 0. Decode uses CONSIG[31:21]. Fields: Rd/Rt=[4:0], Rn=[9:5], Rm=[20:16].
  - R-type ADD/SUB/AND/ORR/EOR/ADDS/SUBS: SA=Rn, SB=Rm, M=1, DA=Rd, WR=1, EN_ALU=1. SUB forms set invB=1 and C0=1.
  - LSL/LSR: M=0, K = zero-extended CONSIG[15:10].
  - I-type ADDI/SUBI/ADDIS/SUBIS/ANDI/ORRI/EORI: M=0, K = zero-extended CONSIG[21:10].
  - STUR: SA=Rn, K = sign-extended CONSIG[20:12], FS=ADD, EN_ADDR_ALU=1, SB=Rt, EN_B=1, RCS=1, RWE=1.
  - LDUR: same address path with RCS=1, then go to MEM.
  - B: PS=11, PC_SEL=1, K = sign-extended CONSIG[25:0] − 1 (compensates for the fetch increment).
  - BR: SA=Rn, PC_SEL=0, PS=10.
  - CBZ/CBNZ: SA=Rt, M=0, K=0, FS=ADD. PS=11 with K = sign-extended CONSIG[23:5] − 1 only if STAT[0] matches (CBZ: Z=1, CBNZ: Z=0).
  - CBZ/CBNZ compare and branch occur in one EXEC cycle, so K is muxed. The implementation uses the ADD-with-K=0 path on the A bus and routes the branch offset only to the PC mux; K drives the offset when taken.
  - All instructions except LDUR go to FETCH0 after EXEC.
- MEM: hold the LDUR address controls, set ROE=1, DA=Rt, WR=1, then go to FETCH0.
- Illegal opcode: ILLEGAL=1 for one EXEC cycle, no enables asserted. Next state is FETCH0, or HALT when HALT_ON_ILLEGAL=1.
- HALT: all outputs 0, remains in HALT until RST.
- Never assert two DBUS drivers in the same cycle (RAM ROE, EN_B, EN_ALU, EN_PC). Never assert two RABUS drivers in the same cycle.

Optional Feature:
LEGV8_BCOND_EN
- Defined: a 4-bit flag register captures STAT at the end of EXEC for ADDS/SUBS/ADDIS/SUBIS; it resets to 0.
  - B.cond (CONSIG[31:24]=01010100) evaluates CONSIG[3:0] against the flag register. Codes 0x0–0xD are the LEGv8 conditions EQ…LE; 0xE/0xF are never taken.
  - Taken branches use PS=11 and K = sign-extended CONSIG[23:5] − 1.
- Undefined: no flag register; B.cond decodes as illegal.

Test Plan:
- Assert RST mid-EXEC of ADD → STATE=000 immediately, EN_ADDR_PC=1, RCS=1, all other outputs 0.
- CONSIG=0x8B020020 (ADD X0,X1,X2) → FETCH0, FETCH1 (IR=1, PS=01), EXEC with SA=1, SB=2, DA=0, M=1, FS=01000, WR=1, EN_ALU=1; 3 cycles total.
- LDUR X3,[X4,#-8] → EXEC K=0xFFFF_FFFF_FFFF_FFF8, EN_ADDR_ALU=1; MEM ROE=1, DA=3, WR=1; 4 cycles total.
- CBZ X5 with offset +3: STAT[0]=1 → PS=11, K=2; STAT[0]=0 → PS=00.
- Opcode 0x00000000 with HALT_ON_ILLEGAL=1 → ILLEGAL pulses once, STATE=100 persists until RST.
- With LEGV8_BCOND_EN: SUBS sets Z=1, then B.EQ → taken; B.NE → PS=00. Without the macro, B.EQ raises ILLEGAL.
